// File: rtl/dbg_fifo_rdout_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dbg_fifo_rdout_ctrl_pkg
// Shared constants for the debug-FIFO readout controller: default widths,
// FSM state encoding and the beat tags that mark header, high-half and
// trailer beats in the 16-bit output stream.
// -----------------------------------------------------------------------------
package dbg_fifo_rdout_ctrl_pkg;

   localparam int DW_DEF = 24;   // FIFO word width
   localparam int CW_DEF = 9;    // word-count width (matches FIFO count)

   // FSM state encoding
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HDR  = 3'd1;
   localparam logic [2:0] ST_LO   = 3'd2;
   localparam logic [2:0] ST_HI   = 3'd3;
   localparam logic [2:0] ST_GAP  = 3'd4;
   localparam logic [2:0] ST_TRL  = 3'd5;

   // Beat tags
   localparam logic [6:0] HDR_TAG = 7'b1010101;  // header:  {HDR_TAG, target}
   localparam logic [6:0] TRL_TAG = 7'b0101010;  // trailer: {TRL_TAG, word count}
   localparam logic [7:0] HI_TAG  = 8'hDB;       // high half: {HI_TAG, data[23:16]}

endpackage

// File: rtl/dbg_fifo_rdout_ctrl_if.sv
// -----------------------------------------------------------------------------
// dbg_fifo_rdout_ctrl_if
// Bundles the FIFO side, the readout command and the host beat stream of the
// readout controller.
//   FIFO side : ff_data, ff_empty, ff_full (in to ctrl), fre (out of ctrl)
//   Command   : rd_req, rd_nwords, abort (in to ctrl)
//   Host side : host_rdy (in to ctrl); dout, dvalid, dlast (out of ctrl)
//   Status    : busy, ovf, word_cnt (out of ctrl)
// Modports: master = the controller, slave = the FIFO/host environment.
// -----------------------------------------------------------------------------
interface dbg_fifo_rdout_ctrl_if
   import dbg_fifo_rdout_ctrl_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
);
   logic [DW-1:0] ff_data;
   logic          ff_empty;
   logic          ff_full;
   logic          fre;
   logic          rd_req;
   logic [CW-1:0] rd_nwords;
   logic          abort;
   logic          host_rdy;
   logic [15:0]   dout;
   logic          dvalid;
   logic          dlast;
   logic          busy;
   logic          ovf;
   logic [CW-1:0] word_cnt;

   modport master (
      input  ff_data, ff_empty, ff_full, rd_req, rd_nwords, abort, host_rdy,
      output fre, dout, dvalid, dlast, busy, ovf, word_cnt
   );

   modport slave (
      output ff_data, ff_empty, ff_full, rd_req, rd_nwords, abort, host_rdy,
      input  fre, dout, dvalid, dlast, busy, ovf, word_cnt
   );
endinterface

// File: rtl/dbg_fifo_rdout_ctrl.sv
// -----------------------------------------------------------------------------
// dbg_fifo_rdout_ctrl
// Reads words from an external first-word-fall-through FIFO and streams them
// to a host as 16-bit beats: header, then LO/HI beat pairs per word, then a
// trailer carrying the number of words popped.
// Ports:
//   clk40 - sole clock, rising edge
//   rst_b - asynchronous active-low reset
//   io    - dbg_fifo_rdout_ctrl_if.master (FIFO, command, host, status)
// -----------------------------------------------------------------------------
module dbg_fifo_rdout_ctrl
   import dbg_fifo_rdout_ctrl_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic                 clk40,
   input  logic                 rst_b,
   dbg_fifo_rdout_ctrl_if.master io
);

   logic [2:0]    state_reg;
   logic [CW-1:0] target_reg;
   logic [CW-1:0] word_cnt_reg;
   logic [15:0]   dout_reg;
   logic          dvalid_reg;
   logic          dlast_reg;
   logic          ovf_reg;

   logic [DW-1:0] head;
   logic          xfer;
   logic          pop;
   logic          accept;
   logic          cnt_done;
   logic [15:0]   lo_beat;
   logic [15:0]   hi_beat;
   logic [15:0]   trl_beat;

   assign head     = io.ff_data;
   // ABORT suppresses any transfer in its cycle, so nothing is consumed.
   assign xfer     = dvalid_reg & io.host_rdy & ~io.abort;
   // The word is popped only when its high half is accepted by the host.
   assign pop      = (state_reg == ST_HI) & xfer & ~io.ff_empty;
   assign accept   = (state_reg == ST_IDLE) & io.rd_req & ~io.abort;
   // Target 0 means drain until empty; 511 is the hard ceiling either way.
   assign cnt_done = ((target_reg != '0) && (word_cnt_reg == target_reg)) ||
                     (&word_cnt_reg);

   // Beat contents are registered on entry to the state that presents them,
   // so DOUT is already valid in the first cycle DVALID is high.
   assign lo_beat  = head[15:0];
   assign hi_beat  = {HI_TAG, head[23:16]};
   assign trl_beat = {TRL_TAG, word_cnt_reg};

   assign io.fre      = pop;
   assign io.dout     = dout_reg;
   assign io.dvalid   = dvalid_reg;
   assign io.dlast    = dlast_reg;
   assign io.busy     = (state_reg != ST_IDLE);
   assign io.ovf      = ovf_reg;
   assign io.word_cnt = word_cnt_reg;

   always_ff @(posedge clk40 or negedge rst_b) begin
      if (!rst_b) begin
         state_reg    <= ST_IDLE;
         target_reg   <= '0;
         word_cnt_reg <= '0;
         dout_reg     <= '0;
         dvalid_reg   <= 1'b0;
         dlast_reg    <= 1'b0;
         ovf_reg      <= 1'b0;
      end else begin
         // Overflow is sticky; a new readout restarts it from this cycle's FULL.
         if (accept)
            ovf_reg <= io.ff_full;
         else if (io.ff_full)
            ovf_reg <= 1'b1;

         if (io.abort) begin
            state_reg  <= ST_IDLE;
            dvalid_reg <= 1'b0;
            dlast_reg  <= 1'b0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (io.rd_req) begin
                     state_reg    <= ST_HDR;
                     target_reg   <= io.rd_nwords;
                     word_cnt_reg <= '0;
                     dout_reg     <= {HDR_TAG, io.rd_nwords};
                     dvalid_reg   <= 1'b1;
                  end
               end
               ST_HDR: begin
                  if (xfer) begin
                     // Empty FIFO skips straight to the trailer, no data beat.
                     if (io.ff_empty) begin
                        state_reg <= ST_TRL;
                        dout_reg  <= trl_beat;
                        dlast_reg <= 1'b1;
                     end else begin
                        state_reg <= ST_LO;
                        dout_reg  <= lo_beat;
                     end
                  end
               end
               ST_LO: begin
                  if (xfer) begin
                     state_reg <= ST_HI;
                     dout_reg  <= hi_beat;
                  end
               end
               ST_HI: begin
                  // A FWFT FIFO cannot run empty while its head is held here.
                  if (pop) begin
                     state_reg    <= ST_GAP;
                     dvalid_reg   <= 1'b0;
                     word_cnt_reg <= word_cnt_reg + 1'b1;
                  end
               end
               ST_GAP: begin
                  // The popped word has left the head; the next word is on ff_data.
                  dvalid_reg <= 1'b1;
                  if (cnt_done || io.ff_empty) begin
                     state_reg <= ST_TRL;
                     dout_reg  <= trl_beat;
                     dlast_reg <= 1'b1;
                  end else begin
                     state_reg <= ST_LO;
                     dout_reg  <= lo_beat;
                  end
               end
               ST_TRL: begin
                  if (xfer) begin
                     state_reg  <= ST_IDLE;
                     dvalid_reg <= 1'b0;
                     dlast_reg  <= 1'b0;
                  end
               end
               default: begin
                  state_reg  <= ST_IDLE;
                  dvalid_reg <= 1'b0;
                  dlast_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dbg_fifo_rdout_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dbg_fifo_rdout_ctrl
// Drives the readout controller from a behavioural FWFT FIFO model and checks
// the beat stream against expected beats queued when each readout is issued.
// -----------------------------------------------------------------------------
module tb_dbg_fifo_rdout_ctrl;

   logic clk40 = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk40 = ~clk40;

   dbg_fifo_rdout_ctrl_if #(.DW(24), .CW(9)) io ();

   dbg_fifo_rdout_ctrl #(.DW(24), .CW(9)) dut (
      .clk40 (clk40),
      .rst_b (rst_b),
      .io    (io)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [16:0] exp_q[$];     // {dlast, dout}
   logic [23:0] fifo_q[$];
   int          pop_req = 0;  // FRE pulses seen
   int          pop_done = 0; // pops applied to the FIFO model
   int          fre_cnt = 0;
   int          rdy_mode = 0; // 0 always, 1 toggle, 2 random, 3 manual
   logic        man_rdy = 1'b1;
   int          beat_no = 0;
   logic        prev_stall = 1'b0;
   logic [16:0] prev_beat = '0;

   int          exp_k;
   int          exp_left;
   int          fre_start;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // FWFT FIFO model: pops requested by FRE take effect just after the edge.
   always @(posedge clk40) begin
      #1;
      while (pop_done < pop_req) begin
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         pop_done++;
      end
      io.ff_empty = (fifo_q.size() == 0);
      io.ff_data  = (fifo_q.size() > 0) ? fifo_q[0] : 24'h0;
   end

   // Host ready generator
   always @(posedge clk40) begin
      #1;
      case (rdy_mode)
         0: io.host_rdy = 1'b1;
         1: io.host_rdy = ~io.host_rdy;
         2: io.host_rdy = 1'($urandom_range(0, 1));
         default: io.host_rdy = man_rdy;
      endcase
   end

   // Monitor / scoreboard
   always @(negedge clk40) begin
      if (rst_b) begin
         if (prev_stall) begin
            chk("stall_dvalid", {31'd0, io.dvalid}, 32'd1);
            chk("stall_beat", {15'd0, io.dlast, io.dout}, {15'd0, prev_beat});
         end
         if (io.dvalid && io.host_rdy && !io.abort) begin
            beat_no++;
            $display("beat %0d: dout=%h dlast=%b", beat_no, io.dout, io.dlast);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL beat: got unexpected %h, required none", {io.dlast, io.dout});
            end else begin
               chk("beat", {15'd0, io.dlast, io.dout}, {15'd0, exp_q.pop_front()});
            end
         end
         if (io.fre) begin
            fre_cnt++;
            pop_req++;
            chk("fre_while_empty", {31'd0, io.ff_empty}, 32'd0);
         end
         prev_stall = io.dvalid && !io.host_rdy && !io.abort;
         prev_beat  = {io.dlast, io.dout};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk40);
      #1;
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(24'($urandom()));
   endtask

   // Builds the expected beat list from the FIFO contents and issues RD_REQ.
   // Trailer = tag 0101010 in bits 15:9, count in 8:0 (0x5403 for 3 words).
   task automatic start_rd(input int n, input int hold);
      int len;
      int k;
      logic [23:0] w;
      len = fifo_q.size();
      if (n == 0) k = (len < 511) ? len : 511;
      else        k = (len < n) ? len : n;
      exp_q.push_back({1'b0, 16'hAA00 + 16'(n)});
      for (int i = 0; i < k; i++) begin
         w = fifo_q[i];
         exp_q.push_back({1'b0, w[15:0]});
         exp_q.push_back({1'b0, 16'hDB00 + 16'(w >> 16)});
      end
      exp_q.push_back({1'b1, 16'h5400 + 16'(k)});
      exp_k     = k;
      exp_left  = len - k;
      fre_start = fre_cnt;
      $display("readout: nwords=%0d fifo=%0d expect %0d words", n, len, k);
      io.rd_nwords = 9'(n);
      io.rd_req    = 1'b1;
      repeat (hold) tick();
      io.rd_req    = 1'b0;
   endtask

   task automatic finish_rd(input logic exp_ovf);
      int budget = 20000;
      @(negedge clk40);
      while (io.busy && budget > 0) begin
         @(negedge clk40);
         budget--;
      end
      if (budget == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: busy=1, required 0");
         tick();
         io.abort = 1'b1;
         tick();
         io.abort = 1'b0;
         exp_q.delete();
      end
      chk("beats_left", exp_q.size(), 0);
      chk("fre_count", fre_cnt - fre_start, exp_k);
      chk("word_cnt", {23'd0, io.word_cnt}, exp_k);
      chk("fifo_left", fifo_q.size(), exp_left);
      chk("ovf", {31'd0, io.ovf}, {31'd0, exp_ovf});
   endtask

   initial begin
      io.rd_req    = 1'b0;
      io.rd_nwords = '0;
      io.abort     = 1'b0;
      io.ff_full   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk40);
      chk("rst_fre", {31'd0, io.fre}, 0);
      chk("rst_dvalid", {31'd0, io.dvalid}, 0);
      chk("rst_dlast", {31'd0, io.dlast}, 0);
      chk("rst_busy", {31'd0, io.busy}, 0);
      chk("rst_ovf", {31'd0, io.ovf}, 0);
      chk("rst_dout", {16'd0, io.dout}, 0);
      chk("rst_word_cnt", {23'd0, io.word_cnt}, 0);
      tick();
      rst_b = 1'b1;
      repeat (3) begin
         @(negedge clk40);
         chk("post_rst_dvalid", {31'd0, io.dvalid}, 0);
         chk("post_rst_fre", {31'd0, io.fre}, 0);
      end

      // Three known words, drain mode
      tick();
      fifo_q.push_back(24'hABCDEF);
      fifo_q.push_back(24'h123456);
      fifo_q.push_back(24'h000001);
      repeat (2) tick();
      start_rd(0, 1);
      finish_rd(1'b0);

      // Counted readout leaves the rest in the FIFO
      tick();
      push_words(5);
      repeat (2) tick();
      start_rd(2, 1);
      finish_rd(1'b0);
      @(negedge clk40);
      chk("ff_empty_after", {31'd0, io.ff_empty}, 0);
      // Drain the rest with random ready and RD_REQ held across the start
      tick();
      rdy_mode = 2;
      start_rd(0, 3);
      finish_rd(1'b0);

      // Toggling host ready
      tick();
      push_words(6);
      rdy_mode = 1;
      repeat (2) tick();
      start_rd(0, 1);
      finish_rd(1'b0);

      // Empty FIFO, drain and counted
      rdy_mode = 0;
      repeat (3) tick();
      start_rd(0, 1);
      finish_rd(1'b0);
      tick();
      start_rd(5, 1);
      finish_rd(1'b0);

      // Overflow: pulse mid-readout, then cleared by next accept
      tick();
      push_words(4);
      repeat (2) tick();
      start_rd(0, 1);
      repeat (3) tick();
      io.ff_full = 1'b1;
      tick();
      io.ff_full = 1'b0;
      finish_rd(1'b1);
      tick();
      push_words(2);
      repeat (2) tick();
      start_rd(0, 1);
      @(negedge clk40);
      chk("ovf_cleared", {31'd0, io.ovf}, 0);
      finish_rd(1'b0);
      // FULL on the acceptance cycle itself
      tick();
      push_words(1);
      repeat (2) tick();
      io.ff_full = 1'b1;
      start_rd(0, 1);
      io.ff_full = 1'b0;
      finish_rd(1'b1);

      // ABORT and RD_REQ together in IDLE
      tick();
      push_words(2);
      repeat (2) tick();
      io.rd_req = 1'b1;
      io.abort  = 1'b1;
      tick();
      io.rd_req = 1'b0;
      io.abort  = 1'b0;
      @(negedge clk40);
      chk("abort_wins_busy", {31'd0, io.busy}, 0);
      chk("abort_wins_dvalid", {31'd0, io.dvalid}, 0);

      // ABORT while HI is stalled
      tick();
      push_words(1);
      rdy_mode = 3;
      man_rdy  = 1'b1;
      repeat (2) tick();
      start_rd(0, 1);
      begin
         int xf = 0;
         int budget = 100;
         while (xf < 4 && budget > 0) begin
            @(negedge clk40);
            if (io.dvalid && io.host_rdy) xf++;
            budget--;
         end
         chk("abort_setup_xfers", xf, 4);
         man_rdy = 1'b0;
      end
      repeat (2) @(negedge clk40);
      chk("hi_stalled_dvalid", {31'd0, io.dvalid}, 1);
      chk("hi_stalled_tag", {24'd0, io.dout[15:8]}, 32'hDB);
      tick();
      io.abort = 1'b1;
      @(negedge clk40);
      chk("abort_fre", {31'd0, io.fre}, 0);
      tick();
      io.abort = 1'b0;
      exp_q.delete();
      @(negedge clk40);
      chk("abort_busy", {31'd0, io.busy}, 0);
      chk("abort_dvalid", {31'd0, io.dvalid}, 0);
      chk("abort_pops", fre_cnt - fre_start, 1);
      chk("abort_fifo", fifo_q.size(), 2);
      rdy_mode = 0;
      man_rdy  = 1'b1;
      tick();
      start_rd(0, 1);
      @(negedge clk40);
      chk("restart_word_cnt", {23'd0, io.word_cnt}, 0);
      finish_rd(1'b0);

      // 511-word ceiling in drain mode
      tick();
      push_words(515);
      repeat (2) tick();
      start_rd(0, 1);
      finish_rd(1'b0);
      tick();
      start_rd(3, 1);
      finish_rd(1'b0);
      tick();
      start_rd(0, 1);
      finish_rd(1'b0);

      // Randomized readouts
      for (int it = 0; it < 8; it++) begin
         tick();
         push_words($urandom_range(0, 12));
         rdy_mode = $urandom_range(0, 2);
         repeat (2) tick();
         start_rd($urandom_range(0, 15), $urandom_range(1, 3));
         finish_rd(1'b0);
      end

      // Asynchronous reset mid-readout
      tick();
      push_words(6);
      rdy_mode = 0;
      repeat (2) tick();
      start_rd(0, 1);
      repeat (5) tick();
      #2;
      rst_b = 1'b0;
      #1;
      chk("arst_fre", {31'd0, io.fre}, 0);
      chk("arst_dvalid", {31'd0, io.dvalid}, 0);
      chk("arst_dlast", {31'd0, io.dlast}, 0);
      chk("arst_busy", {31'd0, io.busy}, 0);
      chk("arst_ovf", {31'd0, io.ovf}, 0);
      chk("arst_dout", {16'd0, io.dout}, 0);
      chk("arst_word_cnt", {23'd0, io.word_cnt}, 0);
      exp_q.delete();
      repeat (2) tick();
      rst_b = 1'b1;
      repeat (3) begin
         @(negedge clk40);
         chk("arst_release_dvalid", {31'd0, io.dvalid}, 0);
      end
      tick();
      start_rd(0, 1);
      finish_rd(1'b0);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
